multicore_alu: RTL and testbench

- Registered 8-bit ALU built from three parallel compute cores: arithmetic (add/sub), multiplier, and logic/shift.
- A 4-bit opcode selects one core output, which is captured into a 16-bit result register on each rising clock edge.
- Standalone datapath block driven directly by the control unit; no handshake, one result per cycle.

---
 rtl/multicore_alu.sv | 100 ++++++++++
 tb/tb_multicore_alu.sv | 105 ++++++++++
 2 files changed

// File: rtl/multicore_alu.sv
// Registered ALU: arithmetic, multiplier and logic/shift cores evaluated in parallel,
// opcode-selected into a double-width result register.
module multicore_alu #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     A,
   input  logic [DATA_W-1:0]     B,
   input  logic [3:0]            opcode,
   output logic [2*DATA_W-1:0]   result
);

   localparam int RW    = 2 * DATA_W;
   localparam int SHL_W = $clog2(RW);
   localparam int SHR_W = $clog2(DATA_W);

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_MUL = 4'd2,
      OP_AND = 4'd4,
      OP_OR  = 4'd5,
      OP_XOR = 4'd6,
      OP_NOT = 4'd7,
      OP_SHL = 4'd8,
      OP_SHR = 4'd9,
      OP_CMP = 4'd10
   } op_t;

   logic [RW-1:0]     a_ext;
   logic [RW-1:0]     b_ext;
   logic [RW-1:0]     add_res;
   logic [RW-1:0]     sub_res;
   logic [RW-1:0]     mul_res;
   logic [DATA_W-1:0] and_bits;
   logic [DATA_W-1:0] or_bits;
   logic [DATA_W-1:0] xor_bits;
   logic [DATA_W-1:0] not_bits;
   logic [RW-1:0]     shl_res;
   logic [DATA_W-1:0] shr_bits;
   logic              a_lt_b;
   logic              a_eq_b;
   logic [RW-1:0]     result_next;
   logic [RW-1:0]     result_reg;

   assign a_ext = {{DATA_W{1'b0}}, A};
   assign b_ext = {{DATA_W{1'b0}}, B};

   // Arithmetic core: wide operands give the carry bit on ADD and the 0xFFxx wrap on SUB.
   assign add_res = a_ext + b_ext;
   assign sub_res = a_ext - b_ext;

   // Multiplier core: full-width unsigned product.
   assign mul_res = a_ext * b_ext;

   // Logic core, one slice per operand bit.
   generate
      for (genvar gi = 0; gi < DATA_W; gi++) begin : g_logic
         assign and_bits[gi] = A[gi] & B[gi];
         assign or_bits[gi]  = A[gi] | B[gi];
         assign xor_bits[gi] = A[gi] ^ B[gi];
         assign not_bits[gi] = ~A[gi];
      end
   endgenerate

   // SHL may push bits into the upper half; SHR stays within the operand width.
   assign shl_res  = a_ext << B[SHL_W-1:0];
   assign shr_bits = A >> B[SHR_W-1:0];
   assign a_lt_b   = (A < B);
   assign a_eq_b   = (A == B);

   always_comb begin
      result_next = '0;
      case (opcode)
         OP_ADD:  result_next = add_res;
         OP_SUB:  result_next = sub_res;
         OP_MUL:  result_next = mul_res;
         OP_AND:  result_next = {{DATA_W{1'b0}}, and_bits};
         OP_OR:   result_next = {{DATA_W{1'b0}}, or_bits};
         OP_XOR:  result_next = {{DATA_W{1'b0}}, xor_bits};
         OP_NOT:  result_next = {{DATA_W{1'b0}}, not_bits};
         OP_SHL:  result_next = shl_res;
         OP_SHR:  result_next = {{DATA_W{1'b0}}, shr_bits};
         OP_CMP:  result_next = {{(RW-2){1'b0}}, a_lt_b, a_eq_b};
         default: result_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         result_reg <= '0;
      end else begin
         result_reg <= result_next;
      end
   end

   assign result = result_reg;

endmodule

// File: tb/tb_multicore_alu.sv
// Directed bench for multicore_alu: each step drives inputs, takes one edge and
// checks the registered result against a hand-computed constant.
module tb_multicore_alu;

   logic        clk;
   logic        rst;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [3:0]  opcode;
   logic [15:0] result;

   int tests_run;
   int tests_failed;

   multicore_alu #(.DATA_W(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .A      (A),
      .B      (B),
      .opcode (opcode),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] expected);
      tests_run++;
      assert (result === expected)
      else begin
         tests_failed++;
         $error("FAIL %s: result=%h expected=%h", tag, result, expected);
      end
      $display("[TB] %-10s A=%h B=%h op=%0d rst=%b result=%h expected=%h",
               tag, A, B, opcode, rst, result, expected);
   endtask

   // Drive inputs, clock one edge, sample 1 ns later.
   task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input string tag,
                       input logic [15:0] expected);
      rst    = r;
      A      = a;
      B      = b;
      opcode = op;
      @(posedge clk);
      #1;
      check(tag, expected);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst    = 1'b0;
      A      = 8'h00;
      B      = 8'h00;
      opcode = 4'd0;
      #2;

      step(1'b0, 8'hAA, 8'h55, 4'd2,  "reset",    16'h0000);
      step(1'b1, 8'hAA, 8'h55, 4'd2,  "rel_mul",  16'h3872);

      step(1'b1, 8'hAA, 8'h55, 4'd0,  "add",      16'h00FF);
      step(1'b1, 8'hAA, 8'h55, 4'd1,  "sub",      16'h0055);
      step(1'b1, 8'hAA, 8'h55, 4'd2,  "mul",      16'h3872);
      step(1'b1, 8'hAA, 8'h55, 4'd3,  "rsvd3",    16'h0000);

      step(1'b1, 8'hFF, 8'hFF, 4'd0,  "add_ovf",  16'h01FE);
      step(1'b1, 8'hFF, 8'hFF, 4'd2,  "mul_max",  16'hFE01);
      step(1'b1, 8'h55, 8'hAA, 4'd1,  "sub_wrap", 16'hFFAB);

      step(1'b1, 8'hAA, 8'h55, 4'd4,  "and",      16'h0000);
      step(1'b1, 8'hAA, 8'h55, 4'd5,  "or",       16'h00FF);
      step(1'b1, 8'hAA, 8'h55, 4'd6,  "xor",      16'h00FF);
      step(1'b1, 8'hAA, 8'h55, 4'd7,  "not",      16'h0055);
      step(1'b1, 8'hC3, 8'h0F, 4'd6,  "xor2",     16'h00CC);

      step(1'b1, 8'h81, 8'h04, 4'd8,  "shl",      16'h0810);
      step(1'b1, 8'h81, 8'h04, 4'd9,  "shr",      16'h0008);
      step(1'b1, 8'hFF, 8'h0F, 4'd8,  "shl_max",  16'h8000);
      step(1'b1, 8'h80, 8'h0F, 4'd9,  "shr_b20",  16'h0001);
      step(1'b1, 8'h10, 8'h20, 4'd10, "cmp_lt",   16'h0002);
      step(1'b1, 8'h33, 8'h33, 4'd10, "cmp_eq",   16'h0001);
      step(1'b1, 8'h40, 8'h20, 4'd10, "cmp_gt",   16'h0000);
      step(1'b1, 8'hAA, 8'h55, 4'd15, "rsvd15",   16'h0000);
      step(1'b1, 8'hAA, 8'h55, 4'd12, "rsvd12",   16'h0000);

      // Latency: opcode changes after the edge must not reach result until the next edge.
      step(1'b1, 8'hAA, 8'h55, 4'd0,  "lat_add",  16'h00FF);
      opcode = 4'd2;
      #3;
      check("lat_hold", 16'h00FF);
      @(posedge clk);
      #1;
      check("lat_mul", 16'h3872);

      // Reset applied together with a new opcode wins.
      step(1'b0, 8'hAA, 8'h55, 4'd5,  "mid_rst",  16'h0000);
      step(1'b1, 8'hAA, 8'h55, 4'd5,  "post_rst", 16'h00FF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
